// File: rtl/button_step_pulser.sv
// button_step_pulser: synchronises and debounces a raw pushbutton into single-cycle step pulses.
// Define AUTO_REPEAT_EN to add hold-to-repeat pulses (REPEAT_DELAY, then every REPEAT_PERIOD).
module button_step_pulser #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic enable,
  output logic step,
  output logic btn_level,
  output logic repeat_active
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;
  logic s1_q, s1_d, s2_q, s2_d, level_q, level_d, step_q, step_d, pulse;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t state_q, state_d;
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_step_pulser: cycle parameters must be >= 1");
  end
`ifdef AUTO_REPEAT_EN
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);
  logic [TW-1:0] timer_q, timer_d;
  logic rep_q, rep_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      rep_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      rep_q   <= rep_d;
    end
  end
  assign repeat_active = rep_q;
`else
  assign repeat_active = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      step_q  <= 1'b0;
      state_q <= IDLE;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      step_q  <= step_d;
      state_q <= state_d;
    end
  end
  always_comb begin
    s1_d    = btn_in;
    s2_d    = s1_q;
    cnt_d   = '0;
    level_d = level_q;
    if (s2_q != level_q) begin
      if (cnt_q == DB_LAST) level_d = ~level_q;
      else cnt_d = cnt_q + 1'b1;
    end
    state_d = state_q;
    pulse   = 1'b0;
`ifdef AUTO_REPEAT_EN
    timer_d = timer_q + 1'b1;
`endif
    // FSM follows the level being registered this edge, so press and release act in the same cycle btn_level changes
    if (!level_d) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      state_d = HELD;
      pulse   = 1'b1;
    end
`ifdef AUTO_REPEAT_EN
    else if ((state_q == HELD && timer_q == RD_LAST) || (state_q == REPEAT && timer_q == RP_LAST)) begin
      state_d = REPEAT;
      pulse   = 1'b1;
    end
    if (pulse || !level_d) timer_d = '0;
    rep_d = state_d == REPEAT;
`endif
    step_d = pulse & enable;
  end
  assign step      = step_q;
  assign btn_level = level_q;
endmodule
